// File: rtl/score4_move_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : score4_move_ctrl                                             |
// | Description : Writer side of the Score 4 board. Accepts column drops,      |
// |               applies gravity, writes the mover's token into the 7x6       |
// |               panel, toggles the turn, samples the external winner checker |
// |               one cycle after each write and declares win or draw.         |
// | Macro       : SCORE4_MOVE_TIMER_EN enables the idle-move forfeit timer.    |
// | Ports       : clk, rst (sync, active-high), new_game (sync clear)          |
// |               drop_req/drop_col  - drop request, column 0..6 (7 illegal)   |
// |               win_exists/win_player - combinational winner checker inputs  |
// |               drop_rdy  - high in IDLE only                                |
// |               illegal   - 1-cycle pulse on a rejected request              |
// |               panel     - [col][row] cell codes, row 0 = bottom            |
// |               turn      - player to move                                   |
// |               game_over/winner/draw - end-of-game status                   |
// |               timeout   - 1-cycle forfeit pulse (timer build only)         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module score4_move_ctrl #(
  parameter logic        FIRST_PLAYER = 1'b0,
  parameter logic [31:0] MOVE_TIMEOUT = 32'd50_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   new_game,
  input  logic                   drop_req,
  input  logic [2:0]             drop_col,
  input  logic                   win_exists,
  input  logic                   win_player,
  output logic                   drop_rdy,
  output logic                   illegal,
  output logic [6:0][5:0][1:0]   panel,
  output logic                   turn,
  output logic                   game_over,
  output logic                   winner,
  output logic                   draw,
  output logic                   timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_CHECK = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [6:0][2:0]  height;
  logic [5:0]       move_cnt;
  logic [2:0]       col;
  logic             clear;
  logic [2:0]       req_height;
  logic             req_legal;

  assign clear     = rst | new_game;
  assign drop_rdy  = (state == S_IDLE);
  assign game_over = (state == S_OVER);

  // Column 7 has no height counter; treat it like a full column.
  always_comb begin
    req_height = 3'd6;
    for (int c = 0; c < 7; c++) begin
      if (drop_col == 3'(c)) req_height = height[c];
    end
    req_legal = (drop_col != 3'd7) && (req_height != 3'd6);
  end

`ifdef SCORE4_MOVE_TIMER_EN
  logic [31:0] idle_cnt;
  logic        expire;
  logic        timeout_r;

  // A request in the expiry cycle takes priority over the forfeit.
  assign expire  = (state == S_IDLE) && !drop_req && (idle_cnt == MOVE_TIMEOUT - 32'd1);
  assign timeout = timeout_r;

  // Held at zero outside IDLE, so it restarts from zero on every entry.
  always_ff @(posedge clk) begin
    if (clear || state != S_IDLE || drop_req || expire) idle_cnt <= 32'd0;
    else                                                 idle_cnt <= idle_cnt + 32'd1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^MOVE_TIMEOUT;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clear) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (drop_req && req_legal) state_nx = S_WRITE;
      S_WRITE: state_nx = S_CHECK;
      S_CHECK: state_nx = (win_exists || move_cnt == 6'd42) ? S_OVER : S_IDLE;
      S_OVER:  state_nx = S_OVER;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      panel     <= '0;
      height    <= '0;
      move_cnt  <= 6'd0;
      col       <= 3'd0;
      turn      <= FIRST_PLAYER;
      illegal   <= 1'b0;
      winner    <= 1'b0;
      draw      <= 1'b0;
`ifdef SCORE4_MOVE_TIMER_EN
      timeout_r <= 1'b0;
`endif
    end else begin
      illegal   <= 1'b0;
`ifdef SCORE4_MOVE_TIMER_EN
      timeout_r <= expire;
      if (expire) turn <= ~turn;
`endif
      case (state)
        S_IDLE: begin
          if (drop_req) begin
            if (req_legal) col     <= drop_col;
            else           illegal <= 1'b1;
          end
        end
        S_WRITE: begin
          panel[col][height[col]] <= turn ? 2'b10 : 2'b01;
          height[col]             <= height[col] + 3'd1;
          move_cnt                <= move_cnt + 6'd1;
          turn                    <= ~turn;
        end
        S_CHECK: begin
          // A win on the last free cell is reported as a win, not a draw.
          if (win_exists)              winner <= win_player;
          else if (move_cnt == 6'd42)  draw   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
